// File: rtl/alu_unit.sv
// Registered 32-bit integer ALU for the execute stage: one-cycle latency result
// with zero, signed-greater and signed-overflow flags.
module alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] out,
  output logic        zero,
  output logic        great,
  output logic        overflow
);

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBU  = 6'h03;
  localparam logic [5:0] OP_AND   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_NOR   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;
  localparam logic [5:0] OP_ROTR  = 6'h10;
  localparam logic [5:0] OP_ROTRV = 6'h11;
  localparam logic [5:0] OP_LUI   = 6'h12;

  // Rotate by shifting a doubled copy; amount 0 yields v unchanged.
  function automatic logic [DATA_W-1:0] f_rotr(input logic [DATA_W-1:0] v,
                                                input logic [4:0] n);
    logic [2*DATA_W-1:0] dbl;
    dbl = {v, v} >> n;
    return dbl[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic        [DATA_W-1:0] w_sum;
  logic        [DATA_W-1:0] w_diff;
  logic                     w_ovf_add;
  logic                     w_ovf_sub;
  logic        [4:0]        w_vamt;
  logic        [DATA_W-1:0] w_res;
  logic                     w_ovf;
  logic                     w_great;

  logic        [DATA_W-1:0] r_out;
  logic                     r_zero;
  logic                     r_great;
  logic                     r_overflow;

  assign w_a_s     = a;
  assign w_b_s     = b;
  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_vamt    = a[4:0];
  assign w_ovf_add = (a[31] == b[31]) && (w_sum[31] != a[31]);
  assign w_ovf_sub = (a[31] != b[31]) && (w_diff[31] != a[31]);
  assign w_great   = w_a_s > w_b_s;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alu_op)
      OP_ADD:   begin w_res = w_sum;  w_ovf = w_ovf_add; end
      OP_ADDU:  w_res = w_sum;
      OP_SUB:   begin w_res = w_diff; w_ovf = w_ovf_sub; end
      OP_SUBU:  w_res = w_diff;
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_NOR:   w_res = ~(a | b);
      OP_SLT:   w_res = {31'b0, w_a_s < w_b_s};
      OP_SLTU:  w_res = {31'b0, a < b};
      OP_SLL:   w_res = b << shamt;
      OP_SRL:   w_res = b >> shamt;
      OP_SRA:   w_res = w_b_s >>> shamt;
      OP_SLLV:  w_res = b << w_vamt;
      OP_SRLV:  w_res = b >> w_vamt;
      OP_SRAV:  w_res = w_b_s >>> w_vamt;
      OP_ROTR:  w_res = f_rotr(b, shamt);
      OP_ROTRV: w_res = f_rotr(b, w_vamt);
      OP_LUI:   w_res = {b[15:0], 16'h0000};
      default:  begin w_res = '0; w_ovf = 1'b0; end
    endcase
  end

  // Output register stage; reset forces the idle result (zero flag set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_zero     <= 1'b1;
      r_great    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_out      <= w_res;
      r_zero     <= (w_res == '0);
      r_great    <= w_great;
      r_overflow <= w_ovf;
    end
  end

  assign out      = r_out;
  assign zero     = r_zero;
  assign great    = r_great;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed vectors push hand-computed results,
// a monitor pops and compares one edge later.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic        zero;
  logic        great;
  logic        overflow;

  alu_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .out      (out),
    .zero     (zero),
    .great    (great),
    .overflow (overflow)
  );

  typedef struct {
    string       name;
    logic [31:0] e_out;
    logic        e_zero;
    logic        e_great;
    logic        e_ovf;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic issued  = 1'b0;
  logic tb_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Marks which edges carry a result the scoreboard expects.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_vld <= 1'b0;
    else        tb_vld <= issued;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [4:0] sh,
                       input logic [31:0] eo, input logic ez, input logic eg,
                       input logic eov);
    exp_t e;
    @(negedge clk);
    alu_op = op;
    a      = aa;
    b      = bb;
    shamt  = sh;
    e.name = nm; e.e_out = eo; e.e_zero = ez; e.e_great = eg; e.e_ovf = eov;
    q.push_back(e);
    issued = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    issued = 1'b0;
    alu_op = 6'($urandom);
    a      = $urandom;
    b      = $urandom;
    shamt  = 5'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tb_vld) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: result presented with no expectation queued");
        end else begin
          e = q.pop_front();
          chk(e.name, "out",      out,             e.e_out);
          chk(e.name, "zero",     {31'b0, zero},     {31'b0, e.e_zero});
          chk(e.name, "great",    {31'b0, great},    {31'b0, e.e_great});
          chk(e.name, "overflow", {31'b0, overflow}, {31'b0, e.e_ovf});
        end
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    chk(nm, "out",      out,             32'h0);
    chk(nm, "zero",     {31'b0, zero},     32'h1);
    chk(nm, "great",    {31'b0, great},    32'h0);
    chk(nm, "overflow", {31'b0, overflow}, 32'h0);
  endtask

  initial begin : stim
    rst_n  = 1'b1;
    alu_op = 6'h00;
    a      = '0;
    b      = '0;
    shamt  = '0;

    // A pending ADD 7+8 is discarded by reset asserted between edges.
    issue("pending", 6'h00, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    issued = 1'b0;
    q.delete();
    alu_op = 6'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    #1;
    chk_reset_state("async_reset");
    @(posedge clk);
    #1;
    chk_reset_state("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    issue("addu_1p1", 6'h01, 32'd1,          32'd1,          5'd0,  32'd2,          1'b0, 1'b0, 1'b0);
    issue("rotr",     6'h10, 32'd3,          32'h9AD39AD3,   5'd4,  32'h39AD39AD,   1'b0, 1'b1, 1'b0);
    issue("rotrv",    6'h11, 32'd3,          32'h9AD39AD3,   5'd4,  32'h735A735A,   1'b0, 1'b1, 1'b0);
    issue("addu",     6'h01, 32'h40034003,   32'h5AD39AD3,   5'd9,  32'h9AD6DAD6,   1'b0, 1'b0, 1'b0);
    issue("add_ovf",  6'h00, 32'h40034003,   32'h5AD39AD3,   5'd9,  32'h9AD6DAD6,   1'b0, 1'b0, 1'b1);
    issue("sub_ovf",  6'h02, 32'hC0034003,   32'h7FD39AD3,   5'd0,  32'h402FA530,   1'b0, 1'b0, 1'b1);
    issue("subu",     6'h03, 32'hC0034003,   32'h7FD39AD3,   5'd0,  32'h402FA530,   1'b0, 1'b0, 1'b0);
    issue("slt",      6'h08, 32'hFFFFFFFF,   32'h00000001,   5'd0,  32'h00000001,   1'b0, 1'b0, 1'b0);
    issue("sltu",     6'h09, 32'hFFFFFFFF,   32'h00000001,   5'd0,  32'h00000000,   1'b1, 1'b0, 1'b0);
    issue("sub_zero", 6'h02, 32'h12345678,   32'h12345678,   5'd0,  32'h00000000,   1'b1, 1'b0, 1'b0);
    issue("sra31",    6'h0C, 32'h00000000,   32'h80000000,   5'd31, 32'hFFFFFFFF,   1'b0, 1'b1, 1'b0);
    issue("srl31",    6'h0B, 32'h00000000,   32'h80000000,   5'd31, 32'h00000001,   1'b0, 1'b1, 1'b0);
    issue("lui",      6'h12, 32'h00000000,   32'h0000ABCD,   5'd7,  32'hABCD0000,   1'b0, 1'b0, 1'b0);
    issue("and",      6'h04, 32'hF0F0FFFF,   32'h0FF0F00F,   5'd0,  32'h00F0F00F,   1'b0, 1'b0, 1'b0);
    issue("or",       6'h05, 32'hF0F0FFFF,   32'h0FF0F00F,   5'd0,  32'hFFF0FFFF,   1'b0, 1'b0, 1'b0);
    issue("xor",      6'h06, 32'hF0F0FFFF,   32'h0FF0F00F,   5'd0,  32'hFF000FF0,   1'b0, 1'b0, 1'b0);
    issue("nor",      6'h07, 32'hF0F0FFFF,   32'h0FF0F00F,   5'd0,  32'h000F0000,   1'b0, 1'b0, 1'b0);
    issue("sllv",     6'h0D, 32'hFFFFFFE4,   32'h00000001,   5'd7,  32'h00000010,   1'b0, 1'b0, 1'b0);
    issue("srav",     6'h0F, 32'h00000024,   32'hF0000000,   5'd1,  32'hFF000000,   1'b0, 1'b1, 1'b0);
    issue("srlv",     6'h0E, 32'h00000024,   32'hF0000000,   5'd1,  32'h0F000000,   1'b0, 1'b1, 1'b0);
    issue("sll_zero", 6'h0A, 32'h00000000,   32'h00000003,   5'd0,  32'h00000003,   1'b0, 1'b0, 1'b0);
    issue("undef",    6'h3F, 32'h7FFFFFFF,   32'h00000001,   5'd3,  32'h00000000,   1'b1, 1'b1, 1'b0);
    issue("add_wrap", 6'h00, 32'h80000000,   32'h80000000,   5'd0,  32'h00000000,   1'b1, 1'b0, 1'b1);
    issue("sub_neg",  6'h02, 32'd5,          32'd7,          5'd0,  32'hFFFFFFFE,   1'b0, 1'b0, 1'b0);
    idle();

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still expected, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
